// File: rtl/riscv16_pkg.sv
// Shared definitions for the 16-bit RISC datapath: word width, register
// address width and ALU operation encodings.
package riscv16_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_INV = 3'b010,
        ALU_SHL = 3'b011,
        ALU_SHR = 3'b100,
        ALU_AND = 3'b101,
        ALU_OR  = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

endpackage

// File: rtl/datapath_alu.sv
// Combinational 16-bit ALU with zero flag; shifts by DATA_W or more yield 0
// through the natural semantics of the shift operators.
module datapath_alu #(
    parameter int unsigned DATA_W = riscv16_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        alu_control,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    import riscv16_pkg::*;

    always_comb begin
        result = '0;
        case (alu_op_e'(alu_control))
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_INV: result = ~a;
            ALU_SHL: result = a << b;
            ALU_SHR: result = a >> b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/datapath_exec_mem.sv
// Execute/memory stage: register file, ALU, word-addressed data memory and
// write-back mux. Reads are combinational; writes commit on the rising edge.
module datapath_exec_mem #(
    parameter int unsigned DATA_W    = riscv16_pkg::DATA_W,
    parameter int unsigned REG_N     = 8,
    parameter int unsigned MEM_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        reg_read_addr_1,
    input  logic [2:0]        reg_read_addr_2,
    input  logic [2:0]        reg_write_dest,
    input  logic              reg_write,
    input  logic              alu_src,
    input  logic [DATA_W-1:0] imm,
    input  logic [2:0]        alu_control,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    output logic [DATA_W-1:0] reg_read_data_1,
    output logic [DATA_W-1:0] reg_read_data_2,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic [DATA_W-1:0] mem_read_data
);

    localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0] regs [REG_N];
    logic [DATA_W-1:0] mem  [MEM_DEPTH];
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] mem_addr;

    assign reg_read_data_1 = regs[reg_read_addr_1];
    assign reg_read_data_2 = regs[reg_read_addr_2];
    assign alu_b           = alu_src ? imm : reg_read_data_2;

    datapath_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a           (reg_read_data_1),
        .b           (alu_b),
        .alu_control (alu_control),
        .result      (alu_result),
        .zero        (zero)
    );

    // Upper address bits are dropped, so accesses wrap modulo MEM_DEPTH.
    assign mem_addr      = alu_result[ADDR_W-1:0];
    assign mem_read_data = mem_read ? mem[mem_addr] : '0;
    assign wb_data       = mem_to_reg ? mem_read_data : alu_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write) begin
            regs[reg_write_dest] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_write) begin
            mem[mem_addr] <= reg_read_data_2;
        end
    end

endmodule

// File: tb/tb_datapath_exec_mem.sv
// Randomized and directed self-checking bench for datapath_exec_mem against
// an array-based reference model of the register file, ALU and memory.
module tb_datapath_exec_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  reg_read_addr_1, reg_read_addr_2, reg_write_dest;
    logic        reg_write, alu_src, mem_read, mem_write, mem_to_reg;
    logic [15:0] imm;
    logic [2:0]  alu_control;
    logic [15:0] reg_read_data_1, reg_read_data_2, alu_result, mem_read_data;
    logic        zero;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_regs [8];
    logic [15:0] m_mem  [8];

    datapath_exec_mem #(
        .DATA_W(16),
        .REG_N(8),
        .MEM_DEPTH(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .reg_read_addr_1 (reg_read_addr_1),
        .reg_read_addr_2 (reg_read_addr_2),
        .reg_write_dest  (reg_write_dest),
        .reg_write       (reg_write),
        .alu_src         (alu_src),
        .imm             (imm),
        .alu_control     (alu_control),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_to_reg      (mem_to_reg),
        .reg_read_data_1 (reg_read_data_1),
        .reg_read_data_2 (reg_read_data_2),
        .alu_result      (alu_result),
        .zero            (zero),
        .mem_read_data   (mem_read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        int unsigned ua, ub;
        ua = a;
        ub = b;
        case (op)
            3'd0: return 16'((ua + ub) % 65536);
            3'd1: return 16'((ua + 65536 - ub) % 65536);
            3'd2: return 16'(65535 - ua);
            3'd3: return (ub >= 16) ? 16'h0000 : 16'((ua * (32'd1 << ub)) % 65536);
            3'd4: return (ub >= 16) ? 16'h0000 : 16'(ua / (32'd1 << ub));
            3'd5: return a & b;
            3'd6: return a | b;
            default: return (ua < ub) ? 16'h0001 : 16'h0000;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = '0;
            m_mem[i]  = '0;
        end
    endtask

    task automatic drive(input logic [2:0] ra1, input logic [2:0] ra2, input logic [2:0] rd,
                         input logic rw, input logic src, input logic [15:0] im,
                         input logic [2:0] op, input logic mr, input logic mw, input logic m2r);
        reg_read_addr_1 = ra1;
        reg_read_addr_2 = ra2;
        reg_write_dest  = rd;
        reg_write       = rw;
        alu_src         = src;
        imm             = im;
        alu_control     = op;
        mem_read        = mr;
        mem_write       = mw;
        mem_to_reg      = m2r;
    endtask

    // Compare all outputs against the model, then advance one clock and commit.
    task automatic run_cycle();
        logic [15:0] ea, eb, opb, res, emrd, wb;
        int unsigned addr;
        #2;
        ea   = m_regs[reg_read_addr_1];
        eb   = m_regs[reg_read_addr_2];
        opb  = alu_src ? imm : eb;
        res  = ref_alu(alu_control, ea, opb);
        addr = int'(res) % 8;
        emrd = mem_read ? m_mem[addr] : 16'h0000;
        wb   = mem_to_reg ? emrd : res;
        check("rd1", reg_read_data_1, ea);
        check("rd2", reg_read_data_2, eb);
        check("alu", alu_result, res);
        check("zero", {15'b0, zero}, {15'b0, res == 16'h0000});
        check("mrd", mem_read_data, emrd);
        @(posedge clk);
        if (reg_write) m_regs[reg_write_dest] = wb;
        if (mem_write) m_mem[addr] = eb;
        @(negedge clk);
    endtask

    task automatic set_reg(input logic [2:0] r, input logic [15:0] v);
        drive(r, 3'd0, r, 1'b1, 1'b1, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b0);
        run_cycle();
        drive(r, 3'd0, r, 1'b1, 1'b1, v, 3'd6, 1'b0, 1'b0, 1'b0);
        run_cycle();
    endtask

    task automatic set_mem(input logic [2:0] a, input logic [15:0] v);
        set_reg(3'd6, 16'h0000);
        set_reg(3'd7, v);
        drive(3'd6, 3'd7, 3'd0, 1'b0, 1'b1, {13'b0, a}, 3'd0, 1'b0, 1'b1, 1'b0);
        run_cycle();
    endtask

    task automatic sweep(input string tag, input logic [2:0] op, input logic [15:0] exp);
        drive(3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 16'h0000, op, 1'b0, 1'b0, 1'b0);
        #1;
        check(tag, alu_result, exp);
        run_cycle();
    endtask

    initial begin
        rst = 1'b1;
        model_clear();
        drive(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_rd1", reg_read_data_1, 16'h0000);
        check("rst_zero", {15'b0, zero}, 16'h0001);
        @(negedge clk);
        rst = 1'b0;

        // Mid-run reset clears registers and memory immediately
        set_reg(3'd3, 16'h1234);
        set_mem(3'd2, 16'hBEEF);
        set_reg(3'd6, 16'h0000);
        drive(3'd6, 3'd3, 3'd0, 1'b0, 1'b1, 16'h0002, 3'd0, 1'b1, 1'b0, 1'b0);
        #1;
        check("pre_rst_r3", reg_read_data_2, 16'h1234);
        check("pre_rst_mem2", mem_read_data, 16'hBEEF);
        rst = 1'b1;
        #1;
        model_clear();
        check("rst_r3", reg_read_data_2, 16'h0000);
        check("rst_mem2", mem_read_data, 16'h0000);
        drive(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_add_zero", {15'b0, zero}, 16'h0001);
        @(negedge clk);
        rst = 1'b0;

        // Immediate add with writeback, no same-cycle bypass
        drive(3'd1, 3'd2, 3'd2, 1'b1, 1'b1, 16'h0005, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("addi_nobypass", reg_read_data_2, 16'h0000);
        run_cycle();
        drive(3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("addi_r2", reg_read_data_1, 16'h0005);
        run_cycle();

        set_reg(3'd1, 16'h00F0);
        set_reg(3'd2, 16'h0003);
        sweep("add", 3'd0, 16'h00F3);
        sweep("sub", 3'd1, 16'h00ED);
        sweep("inv", 3'd2, 16'hFF0F);
        sweep("shl", 3'd3, 16'h0780);
        sweep("shr", 3'd4, 16'h001E);
        sweep("and", 3'd5, 16'h0000);
        sweep("or",  3'd6, 16'h00F3);
        sweep("slt0", 3'd7, 16'h0000);
        set_reg(3'd1, 16'h0001);
        set_reg(3'd2, 16'h0002);
        sweep("slt1", 3'd7, 16'h0001);
        set_reg(3'd1, 16'h0005);
        drive(3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0005, 3'd1, 1'b0, 1'b0, 1'b0);
        #1;
        check("sub_zero", {15'b0, zero}, 16'h0001);
        run_cycle();

        // Store then load into r4
        set_reg(3'd1, 16'h0002);
        set_reg(3'd2, 16'hCAFE);
        drive(3'd1, 3'd2, 3'd0, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0);
        run_cycle();
        drive(3'd1, 3'd2, 3'd4, 1'b1, 1'b1, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1);
        #1;
        check("load_data", mem_read_data, 16'hCAFE);
        run_cycle();
        drive(3'd4, 3'd2, 3'd0, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("load_r4", reg_read_data_1, 16'hCAFE);
        check("noread_zero", mem_read_data, 16'h0000);
        run_cycle();

        // Address wrap and -1 + 1
        set_reg(3'd6, 16'h0000);
        drive(3'd6, 3'd0, 3'd0, 1'b0, 1'b1, 16'h000A, 3'd0, 1'b1, 1'b0, 1'b0);
        #1;
        check("wrap_mem2", mem_read_data, 16'hCAFE);
        run_cycle();
        set_reg(3'd1, 16'h0001);
        drive(3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("neg1_plus1", alu_result, 16'h0000);
        check("neg1_zero", {15'b0, zero}, 16'h0001);
        run_cycle();

        // Shift bounds
        set_reg(3'd1, 16'h8001);
        drive(3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 16'd16, 3'd3, 1'b0, 1'b0, 1'b0);
        #1;
        check("shl16", alu_result, 16'h0000);
        run_cycle();
        drive(3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 16'd15, 3'd4, 1'b0, 1'b0, 1'b0);
        #1;
        check("shr15", alu_result, 16'h0001);
        run_cycle();

        // Random traffic; small immediates keep shifts and addresses interesting
        for (int n = 0; n < 400; n++) begin
            drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
